dfp_scaleb_sched: RTL

//  Shares one pipelined 128-bit DFP scaleb unit (fixed LAT, global ce) among NREQ requesters.

---
 rtl/dfp_scaleb_sched_pkg.sv | 26 ++
 rtl/dfp_scaleb_sched_rr_arbiter.sv | 33 +++
 rtl/dfp_scaleb_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dfp_scaleb_sched_pkg.sv
// Shared types and constants for the DFP128 scaleb issue scheduler.
// Holds the operand format, the request record and the default unit latency.
package dfp_scaleb_sched_pkg;

    typedef logic [127:0] DFP128;

    localparam int DFP_SCALEB_LAT  = 2;
    localparam int DFP_SCALEB_TAGW = 4;

    typedef struct packed {
        DFP128                       a;
        logic [31:0]                 b;
        logic [DFP_SCALEB_TAGW-1:0]  tag;
    } dfp_scaleb_req_t;

    // Lowest set bit of a one-hot vector, as an index.
    function automatic int unsigned onehot_index(input logic [31:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            idx = oh[i] ? 32'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dfp_scaleb_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr_i, wrapping around.
// Output is one-hot, or zero when disabled or nobody requests.
module rr_arbiter
    import dfp_scaleb_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Wrap-around priority scan starting just past the last winner.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s        = PW'((32'(ptr_i) + 32'(k)) % 32'(N));
            hit_s        = en_i & ~found_s & req_i[idx_s];
            gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/dfp_scaleb_sched.sv
// Issues requests round-robin into a shared, externally instantiated scaleb unit,
// tracks id/tag alongside it and returns results on one registered response channel.
module dfp_scaleb_sched
    import dfp_scaleb_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = DFP_SCALEB_LAT,
    parameter int TAGW = DFP_SCALEB_TAGW,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][127:0]     req_a,
    input  logic [NREQ-1:0][31:0]      req_b,
    input  logic [NREQ-1:0][TAGW-1:0]  req_tag,
    output logic                       su_ce,
    output logic [127:0]               su_a,
    output logic [31:0]                su_b,
    input  logic [127:0]               su_o,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [TAGW-1:0]            rsp_tag,
    output logic [127:0]               rsp_o,
    output logic [31:0]                issued_cnt
);

    logic [NREQ-1:0]           gnt_s;
    logic                      gnt_any_s;
    logic [IDW-1:0]            gnt_id_s;
    logic [TAGW-1:0]           gnt_tag_s;
    logic                      adv_s;

    logic [LAT-1:0]            vld_q,  vld_d;
    logic [LAT-1:0][IDW-1:0]   id_q,   id_d;
    logic [LAT-1:0][TAGW-1:0]  tag_q,  tag_d;
    logic [IDW-1:0]            ptr_q,  ptr_d;
    logic [31:0]               cnt_q,  cnt_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]            rsp_id_q,    rsp_id_d;
    logic [TAGW-1:0]           rsp_tag_q,   rsp_tag_d;
    logic [127:0]              rsp_o_q,     rsp_o_d;

    // The pipe may move unless its oldest result has nowhere to go.
    assign adv_s = ~vld_q[LAT-1] | ~rsp_valid_q | rsp_ready;

    rr_arbiter #(.N(NREQ), .PW(IDW)) u_arb (
        .req_i (req_valid),
        .en_i  (adv_s & ~flush),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s)
    );

    // One-hot grant steers operands and metadata; nothing granted yields zeros.
    always_comb begin
        gnt_any_s = |gnt_s;
        gnt_id_s  = IDW'(onehot_index(32'(gnt_s)));
        su_a      = '0;
        su_b      = '0;
        gnt_tag_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            su_a      = su_a      | (req_a[i]   & {128{gnt_s[i]}});
            su_b      = su_b      | (req_b[i]   & {32{gnt_s[i]}});
            gnt_tag_s = gnt_tag_s | (req_tag[i] & {TAGW{gnt_s[i]}});
        end
    end

    // Next state: shadow pipe, arbitration pointer, issue counter and response register.
    always_comb begin
        vld_d       = vld_q;
        id_d        = id_q;
        tag_d       = tag_q;
        ptr_d       = gnt_any_s ? gnt_id_s : ptr_q;
        cnt_d       = cnt_q + 32'(gnt_any_s);
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_o_d     = rsp_o_q;

        if (flush) begin
            vld_d = '0;
        end else if (adv_s) begin
            for (int s = LAT-1; s > 0; s--) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
            vld_d[0] = gnt_any_s;
            id_d[0]  = gnt_id_s;
            tag_d[0] = gnt_tag_s;
        end else begin
            vld_d = vld_q;
        end

        // An arriving result beats a simultaneous accept.
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (adv_s && vld_q[LAT-1]) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q[LAT-1];
            rsp_tag_d   = tag_q[LAT-1];
            rsp_o_d     = su_o;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            id_q        <= '0;
            tag_q       <= '0;
            ptr_q       <= IDW'(NREQ-1);
            cnt_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_o_q     <= 128'd0;
        end else begin
            vld_q       <= vld_d;
            id_q        <= id_d;
            tag_q       <= tag_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_o_q     <= rsp_o_d;
        end
    end

    // Flush must still clock the unit so its stale contents drain harmlessly.
    assign su_ce      = adv_s | flush;
    assign req_ready  = gnt_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_o      = rsp_o_q;
    assign issued_cnt = cnt_q;

endmodule
